// File: rtl/memaccess_ctrl.sv
// MemAccess stage sequencer: steps one memory-class instruction through the
// indirect, read and write phases and drives the data memory port.
module memaccess_ctrl #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] M_addr,
  input  logic [DATA_W-1:0] M_Data,
  input  logic [DATA_W-1:0] DMem_dout,
  input  logic              dmem_ready,
  output logic [1:0]        mem_state,
  output logic              M_Control,
  output logic [ADDR_W-1:0] DMem_addr,
  output logic [DATA_W-1:0] DMem_din,
  output logic              DMem_rd,
  output logic              DMem_we,
  output logic              done,
  output logic [DATA_W-1:0] load_data,
  output logic              err
);

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_LDR = 4'b0110;
  localparam logic [OP_W-1:0] OP_ST  = 4'b0011;
  localparam logic [OP_W-1:0] OP_STR = 4'b0111;
  localparam logic [OP_W-1:0] OP_LDI = 4'b1010;
  localparam logic [OP_W-1:0] OP_STI = 4'b1011;

  // Encoding matches what the MemAccess agent monitors on mem_state.
  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WRITE = 2'd1,
    S_IND   = 2'd2,
    S_IDLE  = 2'd3
  } state_t;

  state_t            state_q, state_n;
  logic [OP_W-1:0]   op_q, op_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [ADDR_W-1:0] ptr_q, ptr_n;
  logic              ind_q, ind_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [DATA_W-1:0] load_n;
  logic              done_n, err_n;
  logic              rd_n, we_n, ready_n;
  logic [ADDR_W-1:0] daddr_n;
  logic [DATA_W-1:0] din_n;

  // State and all outputs are flops; outputs are the decode of the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      ptr_q       <= '0;
      ind_q       <= 1'b0;
      cnt_q       <= '0;
      load_data   <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      mem_state   <= 2'd3;
      M_Control   <= 1'b0;
      DMem_rd     <= 1'b0;
      DMem_we     <= 1'b0;
      DMem_addr   <= '0;
      DMem_din    <= '0;
      instr_ready <= 1'b1;
    end else begin
      state_q     <= state_n;
      op_q        <= op_n;
      addr_q      <= addr_n;
      data_q      <= data_n;
      ptr_q       <= ptr_n;
      ind_q       <= ind_n;
      cnt_q       <= cnt_n;
      load_data   <= load_n;
      done        <= done_n;
      err         <= err_n;
      mem_state   <= state_n;
      M_Control   <= ind_n;
      DMem_rd     <= rd_n;
      DMem_we     <= we_n;
      DMem_addr   <= daddr_n;
      DMem_din    <= din_n;
      instr_ready <= ready_n;
    end
  end

  always_comb begin
    state_n = state_q;
    op_n    = op_q;
    addr_n  = addr_q;
    data_n  = data_q;
    ptr_n   = ptr_q;
    ind_n   = ind_q;
    cnt_n   = cnt_q;
    load_n  = load_data;
    done_n  = 1'b0;
    err_n   = 1'b0;

    if (state_q == S_IDLE) begin
      cnt_n = '0;
      if (instr_valid) begin
        op_n   = opcode;
        addr_n = M_addr;
        data_n = M_Data;
        case (opcode)
          OP_LD, OP_LDR:  state_n = S_READ;
          OP_ST, OP_STR:  state_n = S_WRITE;
          OP_LDI, OP_STI: state_n = S_IND;
          default:        done_n  = 1'b1;
        endcase
      end
    end else if (dmem_ready) begin
      cnt_n = '0;
      case (state_q)
        S_IND: begin
          ptr_n   = DMem_dout;
          ind_n   = 1'b1;
          state_n = (op_q == OP_STI) ? S_WRITE : S_READ;
        end
        S_READ: begin
          load_n  = DMem_dout;
          done_n  = 1'b1;
          ind_n   = 1'b0;
          state_n = S_IDLE;
        end
        default: begin
          done_n  = 1'b1;
          ind_n   = 1'b0;
          state_n = S_IDLE;
        end
      endcase
    end else if (TIMEOUT != 0) begin
      // Abort a stalled access; no done, load_data untouched.
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        cnt_n   = '0;
        err_n   = 1'b1;
        ind_n   = 1'b0;
        state_n = S_IDLE;
      end else begin
        cnt_n = cnt_q + CNT_W'(1);
      end
    end

    rd_n    = (state_n == S_READ) || (state_n == S_IND);
    we_n    = (state_n == S_WRITE);
    ready_n = (state_n == S_IDLE);
    daddr_n = ind_n ? ptr_n : addr_n;
    din_n   = (state_n == S_WRITE) ? data_n : '0;
  end

endmodule

// File: tb/tb_memaccess_ctrl.sv
// Directed self-checking bench for memaccess_ctrl: vector table plus
// hand-written wait-state, timeout and reset sequences.
module tb_memaccess_ctrl;

  localparam logic [3:0] LD  = 4'b0010;
  localparam logic [3:0] LDR = 4'b0110;
  localparam logic [3:0] ST  = 4'b0011;
  localparam logic [3:0] LDI = 4'b1010;
  localparam logic [3:0] STI = 4'b1011;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  opcode = '0;
  logic [15:0] M_addr = '0;
  logic [15:0] M_Data = '0;
  logic [15:0] DMem_dout = '0;
  logic        dmem_ready = 1'b0;
  logic [1:0]  mem_state;
  logic        M_Control;
  logic [15:0] DMem_addr;
  logic [15:0] DMem_din;
  logic        DMem_rd;
  logic        DMem_we;
  logic        done;
  logic [15:0] load_data;
  logic        err;

  int checks = 0;
  int failures = 0;

  memaccess_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .M_addr(M_addr), .M_Data(M_Data),
    .DMem_dout(DMem_dout), .dmem_ready(dmem_ready),
    .mem_state(mem_state), .M_Control(M_Control),
    .DMem_addr(DMem_addr), .DMem_din(DMem_din),
    .DMem_rd(DMem_rd), .DMem_we(DMem_we),
    .done(done), .load_data(load_data), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] dout;
    logic        rdy;
    logic [1:0]  e_ms;
    logic        e_mc;
    logic        e_rd;
    logic        e_we;
    logic        e_done;
    logic        e_ready;
    logic [15:0] e_addr;
    logic [15:0] e_din;
    logic [15:0] e_load;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic v, input logic [3:0] op,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] dout, input logic rdy,
                              input logic [1:0] ms, input logic mc,
                              input logic rd, input logic we, input logic dn,
                              input logic rv, input logic [15:0] ea,
                              input logic [15:0] ed, input logic [15:0] el);
    vec_t r;
    r.valid = v;   r.op = op;     r.addr = a;    r.data = d;
    r.dout = dout; r.rdy = rdy;   r.e_ms = ms;   r.e_mc = mc;
    r.e_rd = rd;   r.e_we = we;   r.e_done = dn; r.e_ready = rv;
    r.e_addr = ea; r.e_din = ed;  r.e_load = el;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] dout, input logic rdy);
    instr_valid = v; opcode = op; M_addr = a; M_Data = d;
    DMem_dout = dout; dmem_ready = rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, LD,    16'h3000, 16'h0000, 16'h0000, 1, 2'd0, 0, 1, 0, 0, 0, 16'h3000, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 4'h0,  16'h0000, 16'h0000, 16'hBEEF, 1, 2'd3, 0, 0, 0, 1, 1, 16'h3000, 16'h0000, 16'hBEEF);
    vecs[2]  = mk(1, ST,    16'h2000, 16'hAAAA, 16'h0000, 1, 2'd1, 0, 0, 1, 0, 0, 16'h2000, 16'hAAAA, 16'hBEEF);
    vecs[3]  = mk(0, 4'h0,  16'h0000, 16'h0000, 16'h0000, 1, 2'd3, 0, 0, 0, 1, 1, 16'h2000, 16'h0000, 16'hBEEF);
    vecs[4]  = mk(1, STI,   16'h4000, 16'h1234, 16'h0000, 0, 2'd2, 0, 1, 0, 0, 0, 16'h4000, 16'h0000, 16'hBEEF);
    vecs[5]  = mk(0, 4'h0,  16'h0000, 16'h0000, 16'h5000, 1, 2'd1, 1, 0, 1, 0, 0, 16'h5000, 16'h1234, 16'hBEEF);
    vecs[6]  = mk(0, 4'h0,  16'h0000, 16'h0000, 16'h0000, 1, 2'd3, 0, 0, 0, 1, 1, 16'h4000, 16'h0000, 16'hBEEF);
    vecs[7]  = mk(1, LDI,   16'h0100, 16'h0000, 16'h0000, 0, 2'd2, 0, 1, 0, 0, 0, 16'h0100, 16'h0000, 16'hBEEF);
    vecs[8]  = mk(0, 4'h0,  16'h0000, 16'h0000, 16'h0200, 1, 2'd0, 1, 1, 0, 0, 0, 16'h0200, 16'h0000, 16'hBEEF);
    vecs[9]  = mk(0, 4'h0,  16'h0000, 16'h0000, 16'hCAFE, 1, 2'd3, 0, 0, 0, 1, 1, 16'h0100, 16'h0000, 16'hCAFE);
    vecs[10] = mk(1, 4'h1,  16'h7777, 16'h5555, 16'h0000, 0, 2'd3, 0, 0, 0, 1, 1, 16'h7777, 16'h0000, 16'hCAFE);
    vecs[11] = mk(0, 4'h0,  16'h0000, 16'h0000, 16'h1111, 1, 2'd3, 0, 0, 0, 0, 1, 16'h7777, 16'h0000, 16'hCAFE);
    vecs[12] = mk(1, 4'hF,  16'h00F0, 16'h0000, 16'h0000, 0, 2'd3, 0, 0, 0, 1, 1, 16'h00F0, 16'h0000, 16'hCAFE);

    // Reset asserted mid-cycle must take effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst.mem_state", 32'(mem_state), 32'd3);
    chk("rst.instr_ready", 32'(instr_ready), 32'd1);
    chk("rst.rd_we", 32'({DMem_rd, DMem_we, M_Control}), 32'd0);
    chk("rst.addr_din", 32'({DMem_addr, DMem_din}), 32'd0);
    chk("rst.done_err_load", 32'({done, err, load_data}), 32'd0);
    step();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].valid, vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].dout, vecs[i].rdy);
      step();
      chk($sformatf("vec%0d.mem_state", i), 32'(mem_state), 32'(vecs[i].e_ms));
      chk($sformatf("vec%0d.M_Control", i), 32'(M_Control), 32'(vecs[i].e_mc));
      chk($sformatf("vec%0d.rd_we", i), 32'({DMem_rd, DMem_we}), 32'({vecs[i].e_rd, vecs[i].e_we}));
      chk($sformatf("vec%0d.done_err", i), 32'({done, err}), 32'({vecs[i].e_done, 1'b0}));
      chk($sformatf("vec%0d.instr_ready", i), 32'(instr_ready), 32'(vecs[i].e_ready));
      chk($sformatf("vec%0d.DMem_addr", i), 32'(DMem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d.DMem_din", i), 32'(DMem_din), 32'(vecs[i].e_din));
      chk($sformatf("vec%0d.load_data", i), 32'(load_data), 32'(vecs[i].e_load));
    end

    // LDR with three wait cycles while a second instruction is held upstream.
    drive(1, LDR, 16'h0A00, 16'h0000, 16'h0000, 0);
    step();
    drive(1, LD, 16'h0B00, 16'h0000, 16'h0000, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ldr.wait%0d.state", k), 32'({mem_state, DMem_rd, DMem_we}), 32'({2'd0, 1'b1, 1'b0}));
      chk($sformatf("ldr.wait%0d.addr", k), 32'(DMem_addr), 32'h0A00);
      chk($sformatf("ldr.wait%0d.ready_done", k), 32'({instr_ready, done}), 32'd0);
      if (k == 3) begin
        dmem_ready = 1'b1;
        DMem_dout = 16'h4242;
      end
      step();
    end
    chk("ldr.done", 32'({done, mem_state, instr_ready}), 32'({1'b1, 2'd3, 1'b1}));
    chk("ldr.load_data", 32'(load_data), 32'h4242);
    DMem_dout = 16'h9999;
    step();
    chk("ldr.second_accept", 32'({mem_state, DMem_rd}), 32'({2'd0, 1'b1}));
    chk("ldr.second_addr", 32'(DMem_addr), 32'h0B00);
    instr_valid = 1'b0;
    step();
    chk("ldr.second_done", 32'({done, load_data}), 32'({1'b1, 16'h9999}));

    // ST that never completes: abort after four cycles in WRITE.
    drive(1, ST, 16'h2222, 16'h3333, 16'h0000, 0);
    step();
    instr_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo.wait%0d", k), 32'({mem_state, DMem_we, err, done}), 32'({2'd1, 1'b1, 1'b0, 1'b0}));
      step();
    end
    chk("tmo.err", 32'({err, done}), 32'({1'b1, 1'b0}));
    chk("tmo.idle", 32'({mem_state, instr_ready, DMem_we}), 32'({2'd3, 1'b1, 1'b0}));
    chk("tmo.load_kept", 32'(load_data), 32'h9999);
    step();
    chk("tmo.err_pulse", 32'(err), 32'd0);

    // Reset during the READ phase of an LDI.
    drive(1, LDI, 16'h0300, 16'h0000, 16'h0000, 0);
    step();
    drive(0, 4'h0, 16'h0000, 16'h0000, 16'h0400, 1);
    step();
    chk("ldi.read", 32'({mem_state, M_Control, DMem_addr}), 32'({2'd0, 1'b1, 16'h0400}));
    dmem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ldi.rst_state", 32'({mem_state, M_Control, DMem_rd, instr_ready}), 32'({2'd3, 1'b0, 1'b0, 1'b1}));
    chk("ldi.rst_addr", 32'(DMem_addr), 32'h0000);
    chk("ldi.rst_load", 32'(load_data), 32'h0000);
    #1 reset = 1'b0;
    step();
    chk("ldi.after_rst_addr", 32'({M_Control, DMem_addr}), 32'd0);

    // Non-memory opcode: done next cycle, no strobes.
    drive(1, 4'h1, 16'h0000, 16'h0000, 16'h0000, 0);
    step();
    instr_valid = 1'b0;
    chk("nop.done", 32'({done, DMem_rd, DMem_we, mem_state}), 32'({1'b1, 1'b0, 1'b0, 2'd3}));
    step();
    chk("nop.pulse", 32'({done, DMem_rd, DMem_we}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
